plugin_recurrence_gen: RTL and testbench
========================================

// Module: plugin_recurrence_gen
// PURPOSE
// - Parametrised iterative accelerator for second-order linear recurrences a(i)=k*a(i-1)+a(i-2).
// - Successor to the single-mode Fibonacci plugin: selectable sequence, configurable widths, abort, overflow/error flags.
// - Sits in the RS5 plugin slot behind the start/busy/done handshake; operands come from the issuing instruction.
// PARAMETERS
// - DATA_WIDTH  32  width of operands, result and sequence terms
// - CNT_WIDTH   16  width of index n and iteration counter; n = operand_a[CNT_WIDTH-1:0], upper bits ignored
// PORTS
// - clk        in   1           single clock, all state on rising edge
// - reset      in   1           synchronous, active-high reset
// - start      in   1           request; accepted only in IDLE
// - abort      in   1           cancel in-flight calculation
// - operand_a  in   DATA_WIDTH  index n
// - operand_b  in   DATA_WIDTH  [1:0] mode: 0 Fibonacci(0,1,k=1), 1 Lucas(2,1,k=1), 2 Pell(0,1,k=2), 3 reserved; rest ignored
// - busy       out  1           high while in CALC
// - done       out  1           one-cycle completion pulse
// - result     out  DATA_WIDTH  a(n) of last completed request; held until next completion
// - overflow   out  1           last completed request exceeded DATA_WIDTH bits
// - error      out  1           last completed request used reserved mode
// BEHAVIOUR
// - Reset (sync, reset=1 at edge): state IDLE; busy=0, done=0, result=0, overflow=0, error=0; working regs 0. Reset mid-CALC discards work, no done.
// - FSM: IDLE -> CALC (start, n>=2, valid mode); IDLE -> FINISH (start and n<2 or mode 3); CALC -> FINISH (counter==n after final step);
//   CALC -> IDLE (abort); FINISH -> IDLE unconditionally.
// - start in CALC/FINISH ignored (not queued). start and abort same cycle in IDLE: start wins. abort in IDLE/FINISH ignored.
// - Accept at cycle 0 latches n, mode, loads a(0), a(1), counter=2, clears working ovf flag.
// - CALC: one term per cycle; next = k*b + a computed at DATA_WIDTH+2 bits; a<=b, b<=next[DATA_WIDTH-1:0]; counter++.
//   Any step with nonzero carry bits sets sticky working ovf.
// - Latency: done high in cycle max(n,1) after accept (n-1 CALC cycles for n>=2). busy high in cycles 1..n-1.
// - FINISH: done=1 for exactly one cycle; result/overflow/error updated same cycle as done rises, held thereafter.
//   n=0 -> a(0); n=1 -> a(1); mode 3 -> result=0, error=1, overflow=0, latency 1.
// - abort in CALC: next cycle IDLE, busy=0, no done; result/overflow/error keep previous completed values.
// - Counter never wraps: n <= 2^CNT_WIDTH-1, counter compare is equality at CNT_WIDTH+1 bits.
// CONFIGURATION
// - PLUGIN_REC_SATURATE_EN defined: on overflow result = all ones (saturated); overflow flag still set.
// - Not defined: result = true a(n) mod 2^DATA_WIDTH (wrap); overflow flag set identically.
// STRUCTURE
// - RS5_pkg: rec_mode_e (FIB, LUCAS, PELL, RSVD), rec_state_e (IDLE, CALC, FINISH), seed constants per mode.
// - Sub-module recurrence_step: combinational next = k*b + a with carry-out/overflow, parametrised DATA_WIDTH.
// - Top: FSM, counter, working regs, output regs.
// TESTING
// - Fib, n=10 -> done in cycle 10, result=55, overflow=0, busy high cycles 1..9.
// - Lucas n=5 -> 11; Pell n=6 -> 70 at cycle 6; Fib n=0 -> result=0, done at cycle 1, busy never high.
// - Fib n=48, DATA_WIDTH=32 -> overflow=1; result=512559680 (wrap) or 0xFFFFFFFF with PLUGIN_REC_SATURATE_EN.
// - Mode 3, n=7 -> done at cycle 1, error=1, result=0; following Fib n=3 -> result=2, error=0.
// - Fib n=20, abort at cycle 5 -> IDLE at cycle 6, no done, result keeps prior value; start mid-CALC ignored.
// - reset asserted at cycle 4 of Fib n=30 -> all outputs 0 next cycle; new start n=2 -> result=1 at cycle 2.

Source files
------------

// File: rtl/plugin_recurrence_gen_pkg.sv
// Shared types for the recurrence plugin: modes, FSM states, seeds.
// Seeds a(0)/a(1) are tiny, so they are kept 2 bits wide and zero-extended.
package plugin_recurrence_gen_pkg;

  typedef enum logic [1:0] {
    FIB   = 2'd0,
    LUCAS = 2'd1,
    PELL  = 2'd2,
    RSVD  = 2'd3
  } rec_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } rec_state_e;

  localparam logic [1:0] FIB_A0   = 2'd0;
  localparam logic [1:0] FIB_A1   = 2'd1;
  localparam logic [1:0] LUCAS_A0 = 2'd2;
  localparam logic [1:0] LUCAS_A1 = 2'd1;
  localparam logic [1:0] PELL_A0  = 2'd0;
  localparam logic [1:0] PELL_A1  = 2'd1;

  function automatic logic [1:0] seed0(input rec_mode_e m);
    logic [1:0] s;
    s = 2'd0;
    case (m)
      FIB:     s = FIB_A0;
      LUCAS:   s = LUCAS_A0;
      PELL:    s = PELL_A0;
      default: s = 2'd0;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] seed1(input rec_mode_e m);
    logic [1:0] s;
    s = 2'd0;
    case (m)
      FIB:     s = FIB_A1;
      LUCAS:   s = LUCAS_A1;
      PELL:    s = PELL_A1;
      default: s = 2'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/plugin_recurrence_gen_step.sv
// One recurrence step: next = k*b + a, k in {1,2} (dbl_i selects k=2).
// Ports: a_i, b_i terms in; next_o truncated term; ovf_o set on carry-out.
module plugin_recurrence_gen_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  dbl_i,
  output logic [DATA_WIDTH-1:0] next_o,
  output logic                  ovf_o
);

  logic [DATA_WIDTH+1:0] kb;
  logic [DATA_WIDTH+1:0] sum;

  always_comb begin
    kb     = dbl_i ? {1'b0, b_i, 1'b0} : {2'b00, b_i};
    sum    = kb + {2'b00, a_i};
    next_o = sum[DATA_WIDTH-1:0];
    ovf_o  = |sum[DATA_WIDTH+1:DATA_WIDTH];
  end

endmodule

// File: rtl/plugin_recurrence_gen.sv
// Iterative a(i)=k*a(i-1)+a(i-2) generator behind start/busy/done.
// Ports: clk, reset (sync high), start, abort, operand_a (n),
// operand_b[1:0] (mode) in; busy, done, result, overflow, error out.
// Macro PLUGIN_REC_SATURATE_EN: saturate result to all ones on overflow.
module plugin_recurrence_gen
  import plugin_recurrence_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  error
);

  localparam int PADW = DATA_WIDTH - 2;

  rec_state_e            state_q, state_d;
  rec_mode_e             mode_q, mode_d;
  logic [CNT_WIDTH-1:0]  n_q, n_d;
  logic [CNT_WIDTH:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  overflow_q, overflow_d;
  logic                  error_q, error_d;

  logic [DATA_WIDTH-1:0] nxt;
  logic                  step_ovf;
  logic                  fin_ovf;
  logic [DATA_WIDTH-1:0] fin_res;
  rec_mode_e             req_mode;
  logic [CNT_WIDTH-1:0]  req_n;
  logic [DATA_WIDTH-1:0] req_a0;
  logic [DATA_WIDTH-1:0] req_a1;
  logic                  unused_bits;

  assign unused_bits = ^{operand_a[DATA_WIDTH-1:CNT_WIDTH],
                         operand_b[DATA_WIDTH-1:2]};

  plugin_recurrence_gen_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .a_i   (a_q),
    .b_i   (b_q),
    .dbl_i (mode_q == PELL),
    .next_o(nxt),
    .ovf_o (step_ovf)
  );

  always_comb begin
    req_mode = rec_mode_e'(operand_b[1:0]);
    req_n    = operand_a[CNT_WIDTH-1:0];
    req_a0   = {{PADW{1'b0}}, seed0(req_mode)};
    req_a1   = {{PADW{1'b0}}, seed1(req_mode)};
    fin_ovf  = ovf_q | step_ovf;
`ifdef PLUGIN_REC_SATURATE_EN
    fin_res  = fin_ovf ? '1 : nxt;
`else
    fin_res  = nxt;
`endif
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    error_d    = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = req_mode;
          n_d    = req_n;
          a_d    = req_a0;
          b_d    = req_a1;
          cnt_d  = (CNT_WIDTH+1)'(2);
          ovf_d  = 1'b0;
          if (req_mode == RSVD) begin
            state_d    = FINISH;
            result_d   = '0;
            overflow_d = 1'b0;
            error_d    = 1'b1;
          end else if (req_n < CNT_WIDTH'(2)) begin
            state_d    = FINISH;
            result_d   = (req_n == '0) ? req_a0 : req_a1;
            overflow_d = 1'b0;
            error_d    = 1'b0;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          a_d   = b_q;
          b_d   = nxt;
          cnt_d = cnt_q + 1'b1;
          ovf_d = fin_ovf;
          // cnt_q is the index of the term produced this cycle
          if (cnt_q == {1'b0, n_q}) begin
            state_d    = FINISH;
            result_d   = fin_res;
            overflow_d = fin_ovf;
            error_d    = 1'b0;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= FIB;
      n_q        <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
    end
  end

  assign busy     = (state_q == CALC);
  assign done     = (state_q == FINISH);
  assign result   = result_q;
  assign overflow = overflow_q;
  assign error    = error_q;

endmodule

// File: tb/tb_plugin_recurrence_gen.sv
// Directed bench for plugin_recurrence_gen (DATA_WIDTH=32).
// Honors PLUGIN_REC_SATURATE_EN for the expected overflow result.
module tb_plugin_recurrence_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        error;

  int vectors;
  int miscompares;

  plugin_recurrence_gen #(
    .DATA_WIDTH(32),
    .CNT_WIDTH (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request; cycle 0 is the accepting edge, sampling #1 after edges.
  task automatic run(input string tag, input int n, input int md,
                     input int lat, input logic [31:0] res,
                     input logic ov, input logic er);
    @(negedge clk);
    operand_a = n;
    operand_b = md;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) tick();
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, c < lat});
      chk({tag, ".done"}, {31'd0, done}, {31'd0, c == lat});
    end
    chk({tag, ".result"}, result, res);
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, ov});
    chk({tag, ".err"}, {31'd0, error}, {31'd0, er});
    tick();
    chk({tag, ".done_off"}, {31'd0, done}, 32'd0);
    chk({tag, ".busy_off"}, {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] fib48_exp;
  logic [31:0] fib50_exp;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    operand_a   = '0;
    operand_b   = '0;
`ifdef PLUGIN_REC_SATURATE_EN
    fib48_exp = 32'hFFFF_FFFF;
    fib50_exp = 32'hFFFF_FFFF;
`else
    fib48_exp = 32'd512559680;
    fib50_exp = 32'd3996334433;
`endif
    tick();
    tick();
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.ovf", {31'd0, overflow}, 32'd0);
    chk("rst.err", {31'd0, error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run("fib10", 10, 0, 10, 32'd55, 1'b0, 1'b0);
    run("lucas5", 5, 1, 5, 32'd11, 1'b0, 1'b0);
    run("pell6", 6, 2, 6, 32'd70, 1'b0, 1'b0);
    run("fib0", 0, 0, 1, 32'd0, 1'b0, 1'b0);
    run("lucas0", 0, 1, 1, 32'd2, 1'b0, 1'b0);
    run("lucas1", 1, 1, 1, 32'd1, 1'b0, 1'b0);
    run("fib2", 2, 0, 2, 32'd1, 1'b0, 1'b0);
    run("fib48", 48, 0, 48, fib48_exp, 1'b1, 1'b0);
    run("fib50", 50, 0, 50, fib50_exp, 1'b1, 1'b0);
    run("fib47", 47, 0, 47, 32'd2971215073, 1'b0, 1'b0);
    // upper operand bits must be ignored
    run("fib_hi", 32'hABCD_0004, 32'h1234_5670, 4, 32'd3, 1'b0, 1'b0);
    run("rsvd7", 7, 3, 1, 32'd0, 1'b0, 1'b1);
    run("fib3", 3, 0, 3, 32'd2, 1'b0, 1'b0);

    // abort at cycle 5 of Fib n=20, with a stray start at cycle 2
    @(negedge clk);
    operand_a = 20;
    operand_b = 0;
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) tick();
      chk("abort.busy", {31'd0, busy}, 32'd1);
      chk("abort.done", {31'd0, done}, 32'd0);
      if (c == 2) begin
        operand_a = 3;
        start     = 1'b1;
      end
      if (c == 3) start = 1'b0;
      if (c == 5) abort = 1'b1;
    end
    tick();
    abort = 1'b0;
    chk("abort.idle", {31'd0, busy}, 32'd0);
    chk("abort.result", result, 32'd2);
    for (int c = 0; c < 20; c++) begin
      chk("abort.nodone", {31'd0, done | busy}, 32'd0);
      tick();
    end

    // reset at cycle 4 of Fib n=30
    @(negedge clk);
    operand_a = 30;
    operand_b = 0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      chk("rst30.busy", {31'd0, busy}, 32'd1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst30.busy", {31'd0, busy}, 32'd0);
    chk("rst30.done", {31'd0, done}, 32'd0);
    chk("rst30.result", result, 32'd0);
    chk("rst30.ovf", {31'd0, overflow}, 32'd0);
    chk("rst30.err", {31'd0, error}, 32'd0);
    for (int c = 0; c < 30; c++) begin
      chk("rst30.nodone", {31'd0, done}, 32'd0);
      tick();
    end
    run("post_rst", 2, 0, 2, 32'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
